rf_wr_arb: RTL and testbench

Register-file write-port arbiter for the rv32 pipeline. It shares the single register-file write port between the in-order writeback stage (driven by `wb_ctl`'s selected result) and the multi-cycle load unit's returning data. The load unit's results are buffered in a small FIFO. The pipeline has priority, but an ageing counter bounds how long a load can wait; when the bound is reached, the block forces the load through and stalls the writeback stage for one cycle. It also exports a pending-destination mask that the hazard unit uses to hold back younger writers to registers with loads still outstanding.

---
 rtl/rf_wr_arb.sv | 161 ++++++++++++++++
 tb/tb_rf_wr_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wr_arb.sv
// rf_wr_arb: register-file write-port arbiter.
//
// Shares the single register-file write port between the in-order writeback
// stage and the multi-cycle load unit. Load results are buffered in a small
// FIFO. The pipeline normally wins. An ageing counter forces the FIFO head
// through after MAX_WAIT denied cycles, and stalls writeback for that cycle.
//
// Ports:
//   clk, rst                          clock (rising edge), sync active-high reset
//   pipe_wb_valid/rd/data             writeback stage result
//   pipe_stall                        writeback denied, stage must hold its result
//   ld_valid/rd/data, ld_ready        load-unit result, valid/ready handshake
//   rf_we/rf_waddr/rf_wdata           registered register-file write port
//   pend_mask                         one bit per register with a buffered load
module rf_wr_arb #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wb_valid,
  input  logic [4:0]  pipe_wb_rd,
  input  logic [31:0] pipe_wb_data,
  output logic        pipe_stall,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pend_mask
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MAX_W = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_FORCE
  } state_e;

  // Ageing counter saturates at MAX_WAIT and never wraps.
  function automatic logic [WCW-1:0] sat_inc(input logic [WCW-1:0] v);
    if (v == MAX_W) return v;
    else            return v + 1'b1;
  endfunction

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;

  state_e     state;
  logic       full, empty;
  logic       push, grant_pipe, grant_ld;
  logic [31:0] pm;

  assign full     = &vld_q;
  assign empty    = ~|vld_q;
  assign ld_ready = ~full & ~rst;
  // rd 0 loads complete the handshake but are dropped, so no entry ever targets x0.
  assign push     = ld_valid & ld_ready & (|ld_rd);

  // Control state is a pure decode of registered occupancy and age.
  always_comb begin
    if (empty)                    state = S_IDLE;
    else if (wait_cnt_q == MAX_W) state = S_FORCE;
    else                          state = S_PEND;
  end

  always_comb begin
    grant_pipe = 1'b0;
    grant_ld   = 1'b0;
    pipe_stall = 1'b0;
    wait_cnt_d = wait_cnt_q;
    case (state)
      S_IDLE: begin
        grant_pipe = pipe_wb_valid;
        wait_cnt_d = '0;
      end
      S_PEND: begin
        if (pipe_wb_valid) begin
          grant_pipe = 1'b1;
          wait_cnt_d = sat_inc(wait_cnt_q);
        end else begin
          grant_ld   = 1'b1;
          wait_cnt_d = '0;
        end
      end
      S_FORCE: begin
        grant_ld   = 1'b1;
        wait_cnt_d = '0;
        pipe_stall = pipe_wb_valid & ~rst;
      end
      default: wait_cnt_d = '0;
    endcase
  end

  // Pop clears the head before push sets the tail; when not full the two
  // pointers differ whenever both happen, so the order is immaterial.
  always_comb begin
    vld_d = vld_q;
    if (grant_ld) vld_d[rd_ptr_q] = 1'b0;
    if (push)     vld_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    pm = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pm = pm | (32'd1 << rd_mem_q[i]);
    end
  end

  assign pend_mask = rst ? 32'd0 : (pm & ~32'd1);

  // Control state and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wait_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      vld_q      <= vld_d;
      wait_cnt_q <= wait_cnt_d;
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (grant_ld) rd_ptr_q <= rd_ptr_q + 1'b1;
      rf_we_q <= (grant_pipe & (|pipe_wb_rd)) | grant_ld;
      if (grant_ld) begin
        rf_waddr_q <= rd_mem_q[rd_ptr_q];
        rf_wdata_q <= data_mem_q[rd_ptr_q];
      end else if (grant_pipe) begin
        rf_waddr_q <= pipe_wb_rd;
        rf_wdata_q <= pipe_wb_data;
      end
    end
  end

  // FIFO storage: validity is tracked separately, so payload needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= ld_rd;
      data_mem_q[wr_ptr_q] <= ld_data;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wr_arb.sv
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_wb_valid;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  rf_wr_arb #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Advance one clock, then score any register-file write against the queue.
  task automatic cyc();
    wr_t e;
    @(posedge clk);
    #1;
    if (rf_we === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=x%0d=%0h expected=no write", rf_waddr, rf_wdata);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.a});
        chk("wr_data", rf_wdata, e.d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pipe_wb_valid = 1'b0; pipe_wb_rd = '0; pipe_wb_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    cyc();
    cyc();
    #1;
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_stall", {31'd0, pipe_stall}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_pend", pend_mask, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ld_ready", {31'd0, ld_ready}, 32'd1);

    // Pipeline only.
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'h1234;
    #1;
    chk("pipe_stall0", {31'd0, pipe_stall}, 32'd0);
    push_exp(5'd5, 32'h1234);
    cyc();
    chk("pipe_we", {31'd0, rf_we}, 32'd1);
    pipe_wb_valid = 1'b0;
    cyc();
    chk("pipe_we_off", {31'd0, rf_we}, 32'd0);

    // Load with idle pipeline.
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEAD;
    #1;
    chk("ld_ready_idle", {31'd0, ld_ready}, 32'd1);
    cyc();
    ld_valid = 1'b0;
    chk("ld_we_not_yet", {31'd0, rf_we}, 32'd0);
    chk("ld_pend7", pend_mask, 32'h80);
    push_exp(5'd7, 32'hDEAD);
    cyc();
    chk("ld_we", {31'd0, rf_we}, 32'd1);
    chk("ld_pend_clr", pend_mask, 32'd0);

    // Forced grant after MAX_WAIT denials.
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'h300;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99;
    push_exp(5'd3, 32'h300);
    cyc();
    ld_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_wb_data = 32'h300 + i;
      #1;
      chk("force_wait_stall", {31'd0, pipe_stall}, 32'd0);
      chk("force_wait_pend", pend_mask, 32'h200);
      push_exp(5'd3, 32'h300 + i);
      cyc();
    end
    pipe_wb_data = 32'h305;
    #1;
    chk("force_stall", {31'd0, pipe_stall}, 32'd1);
    push_exp(5'd9, 32'h99);
    cyc();
    #1;
    chk("force_after_stall", {31'd0, pipe_stall}, 32'd0);
    push_exp(5'd3, 32'h305);
    cyc();
    pipe_wb_valid = 1'b0;
    cyc();
    chk("force_idle_we", {31'd0, rf_we}, 32'd0);
    chk("force_idle_pend", pend_mask, 32'd0);

    // Backpressure with DEPTH = 2 while the pipeline is busy.
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd4; pipe_wb_data = 32'h400;
    ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'hA10;
    push_exp(5'd4, 32'h400);
    cyc();
    ld_rd = 5'd11; ld_data = 32'hA11; pipe_wb_data = 32'h401;
    #1;
    chk("bp_ready2", {31'd0, ld_ready}, 32'd1);
    push_exp(5'd4, 32'h401);
    cyc();
    ld_rd = 5'd12; ld_data = 32'hA12;
    for (int i = 2; i <= 4; i++) begin
      pipe_wb_data = 32'h400 + i;
      #1;
      chk("bp_full", {31'd0, ld_ready}, 32'd0);
      push_exp(5'd4, 32'h400 + i);
      cyc();
    end
    #1;
    chk("bp_force_stall", {31'd0, pipe_stall}, 32'd1);
    chk("bp_force_full", {31'd0, ld_ready}, 32'd0);
    push_exp(5'd10, 32'hA10);
    cyc();
    #1;
    chk("bp_ready_after_pop", {31'd0, ld_ready}, 32'd1);
    chk("bp_pend_l2", pend_mask, 32'h800);
    push_exp(5'd4, 32'h404);
    cyc();
    ld_valid = 1'b0; pipe_wb_valid = 1'b0;
    chk("bp_pend_l2l3", pend_mask, 32'h1800);
    push_exp(5'd11, 32'hA11);
    cyc();
    push_exp(5'd12, 32'hA12);
    cyc();
    cyc();
    chk("bp_drained_we", {31'd0, rf_we}, 32'd0);
    chk("bp_drained_pend", pend_mask, 32'd0);

    // rd 0 from both sources.
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h5555;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd0; pipe_wb_data = 32'h6666;
    #1;
    chk("rd0_ready", {31'd0, ld_ready}, 32'd1);
    cyc();
    ld_valid = 1'b0; pipe_wb_valid = 1'b0;
    chk("rd0_we", {31'd0, rf_we}, 32'd0);
    chk("rd0_pend", pend_mask, 32'd0);
    chk("rd0_ready_after", {31'd0, ld_ready}, 32'd1);
    cyc();
    chk("rd0_no_late_write", {31'd0, rf_we}, 32'd0);

    // Reset with two entries buffered and wait_cnt = 3.
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd2; pipe_wb_data = 32'h200;
    ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'hB13;
    push_exp(5'd2, 32'h200);
    cyc();
    ld_rd = 5'd14; ld_data = 32'hB14; pipe_wb_data = 32'h201;
    push_exp(5'd2, 32'h201);
    cyc();
    ld_valid = 1'b0;
    pipe_wb_data = 32'h202;
    push_exp(5'd2, 32'h202);
    cyc();
    pipe_wb_data = 32'h203;
    push_exp(5'd2, 32'h203);
    cyc();
    chk("mid_pend", pend_mask, 32'h6000);
    pipe_wb_valid = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mid_rst_we", {31'd0, rf_we}, 32'd0);
    chk("mid_rst_pend", pend_mask, 32'd0);
    chk("mid_rst_ready", {31'd0, ld_ready}, 32'd1);
    for (int i = 0; i < 4; i++) cyc();
    chk("mid_rst_no_stale", {31'd0, rf_we}, 32'd0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
